// File: rtl/seq_mul8u_ctrl_pkg.sv
// seq_mul8u_ctrl_pkg: state encoding, nibble step indices and their shift amounts
package seq_mul8u_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam logic [1:0] STEP_LL = 2'd0;
    localparam logic [1:0] STEP_LH = 2'd1;
    localparam logic [1:0] STEP_HL = 2'd2;
    localparam logic [1:0] STEP_HH = 2'd3;

    localparam logic [3:0] SHIFT_LL = 4'd0;
    localparam logic [3:0] SHIFT_LH = 4'd4;
    localparam logic [3:0] SHIFT_HL = 4'd4;
    localparam logic [3:0] SHIFT_HH = 4'd8;

    function automatic logic [3:0] step_shift(input logic [1:0] step);
        return step == STEP_LL ? SHIFT_LL :
               step == STEP_LH ? SHIFT_LH :
               step == STEP_HL ? SHIFT_HL : SHIFT_HH;
    endfunction

    // Lowest pending step wins, so steps always run in ll, lh, hl, hh order.
    function automatic logic [1:0] low_step(input logic [3:0] mask);
        return mask[STEP_LL] ? STEP_LL :
               mask[STEP_LH] ? STEP_LH :
               mask[STEP_HL] ? STEP_HL : STEP_HH;
    endfunction

endpackage

// File: rtl/seq_mul8u_ctrl_core.sv
// mul4u4_core: combinational exact 4x4 unsigned multiplier
module mul4u4_core (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    assign p = {4'd0, a} * {4'd0, b};

endmodule

// File: rtl/seq_mul8u_ctrl.sv
// seq_mul8u_ctrl: 8x8 unsigned multiplier sequencing four nibble products through one 4x4 core
module seq_mul8u_ctrl
    import seq_mul8u_ctrl_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        busy
);

    state_t      state, state_next;
    logic [7:0]  op_a, op_b;
    logic [3:0]  mask, mask_next, in_mask, mask_rest;
    logic [15:0] acc, acc_next;
    logic [1:0]  step;
    logic [3:0]  core_a, core_b;
    logic [7:0]  pp;
    logic        accept;

    assign accept    = (state == IDLE) && in_valid;
    assign step      = low_step(mask);
    assign mask_rest = mask & (mask - 4'd1);
    assign core_a    = step[1] ? op_a[7:4] : op_a[3:0];
    assign core_b    = step[0] ? op_b[7:4] : op_b[3:0];

    // A step is only worth running when both of its nibbles are nonzero.
    always_comb begin
        in_mask          = 4'd0;
        in_mask[STEP_LL] = !SKIP_ZERO || (in_a[3:0] != 4'd0 && in_b[3:0] != 4'd0);
        in_mask[STEP_LH] = !SKIP_ZERO || (in_a[3:0] != 4'd0 && in_b[7:4] != 4'd0);
        in_mask[STEP_HL] = !SKIP_ZERO || (in_a[7:4] != 4'd0 && in_b[3:0] != 4'd0);
        in_mask[STEP_HH] = !SKIP_ZERO || (in_a[7:4] != 4'd0 && in_b[7:4] != 4'd0);
    end

    mul4u4_core u_core (
        .a (core_a),
        .b (core_b),
        .p (pp)
    );

    // Next-state, step mask and shifted accumulation.
    always_comb begin
        state_next = state;
        mask_next  = mask;
        acc_next   = acc;
        case (state)
            IDLE: if (in_valid) begin
                mask_next  = in_mask;
                acc_next   = 16'd0;
                state_next = in_mask == 4'd0 ? DONE : MUL;
            end
            MUL: begin
                acc_next   = acc + ({8'd0, pp} << step_shift(step));
                mask_next  = mask_rest;
                state_next = mask_rest == 4'd0 ? DONE : MUL;
            end
            DONE: state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    // State, accumulator and operand registers; operands are only captured on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mask  <= 4'd0;
            acc   <= 16'd0;
            op_a  <= 8'd0;
            op_b  <= 8'd0;
        end else begin
            state <= state_next;
            mask  <= mask_next;
            acc   <= acc_next;
            if (accept) begin
                op_a <= in_a;
                op_b <= in_b;
            end
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign out_p     = acc;

endmodule

// File: tb/tb_seq_mul8u_ctrl.sv
// tb_seq_mul8u_ctrl: scoreboard bench driving one instance per SKIP_ZERO setting
module tb_seq_mul8u_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv[2];
    logic [7:0]  ia[2], ib[2];
    logic        ir[2], ov[2], bs[2], orr[2];
    logic [15:0] op[2];
    int          mode[2];
    logic [1:0]  rnd;
    logic [15:0] sb0[$], sb1[$];
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    seq_mul8u_ctrl #(.SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .out_p(op[0]), .busy(bs[0])
    );

    seq_mul8u_ctrl #(.SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .out_p(op[1]), .busy(bs[1])
    );

    // mode 0/1 holds out_ready at that level, mode 2 randomises it every cycle
    initial begin
        rnd = 2'b00;
        forever begin
            @(posedge clk);
            #1 rnd = 2'($urandom);
        end
    end

    assign orr[0] = mode[0] == 2 ? rnd[0] : mode[0] == 1;
    assign orr[1] = mode[1] == 2 ? rnd[1] : mode[1] == 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pop_chk(input int k);
        logic [15:0] e;
        if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
            chk($sformatf("extra_result%0d", k), {16'd0, op[k]}, 32'hFFFF_FFFF);
        end else begin
            e = k == 0 ? sb0.pop_front() : sb1.pop_front();
            chk($sformatf("out_p%0d", k), {16'd0, op[k]}, {16'd0, e});
        end
    endtask

    for (genvar m = 0; m < 2; m++) begin : g_mon
        always @(negedge clk) if (!rst && ov[m] && orr[m]) pop_chk(m);
    end

    // Called at posedge+1; returns at accept posedge+1 with in_valid dropped.
    task automatic send(input int k, input logic [7:0] a, input logic [7:0] b);
        int t;
        iv[k] = 1'b1;
        ia[k] = a;
        ib[k] = b;
        t = 0;
        @(negedge clk);
        while (!ir[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ir[k]) begin
            chk($sformatf("accept_wait%0d", k), ir[k], 1);
        end else if (k == 0) begin
            sb0.push_back(16'(a * b));
        end else begin
            sb1.push_back(16'(a * b));
        end
        @(posedge clk);
        #1 iv[k] = 1'b0;
    endtask

    // Counts the accept edge as 1, then one per edge until out_valid is seen.
    task automatic lat_chk(input int k, input string tag, input int exp);
        int n;
        n = 1;
        while (!ov[k] && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk(tag, n, exp);
    endtask

    task automatic stream(input int k, input int cnt);
        logic [15:0] r;
        for (int i = 0; i < cnt; i++) begin
            r = 16'($urandom);
            if (i < 4) r = {i[1] ? 8'hFF : 8'h00, i[0] ? 8'hFF : 8'h00};
            if (i >= 4 && i < 12) r[15:12] = 4'h0;
            send(k, r[15:8], r[7:0]);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int t;
        rst = 1'b1;
        iv[0] = 1'b0; iv[1] = 1'b0;
        ia[0] = 8'h00; ia[1] = 8'h00;
        ib[0] = 8'h00; ib[1] = 8'h00;
        mode[0] = 1; mode[1] = 1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_in_ready%0d", k), ir[k], 1);
            chk($sformatf("rst_out_valid%0d", k), ov[k], 0);
            chk($sformatf("rst_busy%0d", k), bs[k], 0);
            chk($sformatf("rst_out_p%0d", k), op[k], 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(0, 8'hFF, 8'hFF);
        lat_chk(0, "lat_ff_ff", 5);
        chk("handshake_in_ready", ir[0], 0);
        @(posedge clk);
        #1;
        chk("after_hs_in_ready", ir[0], 1);
        chk("after_hs_out_valid", ov[0], 0);
        send(0, 8'h00, 8'h37);
        lat_chk(0, "lat_noskip_zero", 5);

        send(1, 8'h0F, 8'hF0);
        lat_chk(1, "lat_skip_lh", 2);
        send(1, 8'h00, 8'h37);
        lat_chk(1, "lat_skip_zero", 1);
        send(1, 8'h10, 8'h01);
        lat_chk(1, "lat_skip_hl", 2);

        mode[0] = 0;
        send(0, 8'h12, 8'h34);
        lat_chk(0, "lat_bp", 5);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", ov[0], 1);
            chk("bp_out_p", op[0], 16'h03A8);
            chk("bp_in_ready", ir[0], 0);
            iv[0] = i >= 2 && i < 5;
            ia[0] = 8'h99;
            ib[0] = 8'h77;
            @(posedge clk);
            #1;
        end
        iv[0] = 1'b0;
        mode[0] = 1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", ir[0], 1);

        send(0, 8'hAB, 8'hCD);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_in_ready", ir[0], 1);
        chk("midrst_out_valid", ov[0], 0);
        chk("midrst_busy", bs[0], 0);
        chk("midrst_out_p", op[0], 0);
        sb0.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        send(0, 8'h03, 8'h05);
        lat_chk(0, "lat_after_rst", 5);
        chk("after_rst_out_p", op[0], 16'h000F);

        mode[0] = 2;
        mode[1] = 2;
        fork
            stream(0, 2500);
            stream(1, 3500);
        join
        mode[0] = 1;
        mode[1] = 1;
        t = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && t < 100) begin
            @(posedge clk);
            #1 t++;
        end
        chk("sb0_left", sb0.size(), 0);
        chk("sb1_left", sb1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
